pipe_stage_buf: RTL and testbench

- Parametrised elastic pipeline stage register for the pipelined CPU, replacing the fixed single-entry latch-enable/flush stage registers.
- Holds up to DEPTH payload words in a ring buffer with valid/ready handshakes on both sides, so a stage can absorb back-pressure without a global stall.
- Supports synchronous flush (squash on branch/jump) and a sticky halt that freezes intake once a halting instruction retires from the stage.
- Sits between any two pipeline stages: IF/ID, ID/EX, EX/MEM or MEM/WB.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/pipe_stage_buf_ring_ptr.sv | 29 ++
 rtl/pipe_stage_buf.sv | 107 ++++++++++
 tb/tb_pipe_stage_buf.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: pipeline buffer limits, counter type,
// stage payload structs and small elaboration helpers.
package cpu_types_pkg;

  localparam int PIPE_DEPTH_MAX = 8;

  typedef logic [3:0] pipe_cnt_t;

  // EX/MEM stage payload; callers cast it to and from the buffer's DATA_W.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
  } exmem_t;

  // Pointer width for a ring of 'depth' slots, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_ring_ptr.sv
// Ring-buffer index that steps by one and wraps at DEPTH-1, so any
// depth works, not only powers of two.
module ring_ptr
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // Advance on inc with an explicit wrap; clr returns the index to slot 0.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == PW'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register: a DEPTH-entry ring buffer with
// valid/ready on both sides, synchronous flush and a sticky halt.
module pipe_stage_buf
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halted,
  output logic [CW-1:0]     count
);

  if (DEPTH < 1 || DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be within 1..PIPE_DEPTH_MAX");
  end

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  halt_mem;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              push;
  logic              pop;
  logic              push_act;
  logic              pop_act;

  // Handshakes depend only on registered state, so there is no ready-to-ready path.
  assign in_ready  = (count < CW'(DEPTH)) && !halted;
  assign out_valid = (count != '0);
  assign out_data  = data_mem[rd_ptr];
  assign out_halt  = halt_mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push_act  = push && !flush;
  assign pop_act   = pop && !flush;

  ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .CLK (CLK),
    .RST (RST),
    .clr (flush),
    .inc (push_act),
    .ptr (wr_ptr)
  );

  ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .CLK (CLK),
    .RST (RST),
    .clr (flush),
    .inc (pop_act),
    .ptr (rd_ptr)
  );

  // Write the accepted entry into the slot at wr_ptr; reset wipes all slots.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
      end
      halt_mem <= '0;
    end else if (push_act) begin
      data_mem[wr_ptr] <= in_data;
      halt_mem[wr_ptr] <= in_halt;
    end
  end

  // Occupancy: push and pop together leave it unchanged; flush empties it.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      count <= '0;
    end else begin
      case ({push_act, pop_act})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Halt latches once a halting entry leaves the stage and holds until reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      halted <= 1'b0;
    end else if (pop_act && out_halt) begin
      halted <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_count_max : assert property (@(posedge CLK) disable iff (RST)
    count <= CW'(DEPTH));
  a_count_min : assert property (@(posedge CLK) disable iff (RST)
    (count == '0 && !push) |=> (count == '0));
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: a DEPTH=2 and a DEPTH=3 buffer share one input
// stream and are compared each cycle against queue-based reference models.
module tb_pipe_stage_buf;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_halt = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_halt, a_halted;
  logic [31:0] a_out_data;
  logic [1:0]  a_count;
  logic        b_in_ready, b_out_valid, b_out_halt, b_halted;
  logic [31:0] b_out_data;
  logic [1:0]  b_count;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  logic [32:0] q2[$];
  logic [32:0] q3[$];
  bit          hm2 = 1'b0;
  bit          hm3 = 1'b0;

  always #5 CLK = ~CLK;

  pipe_stage_buf #(.DATA_W(32), .DEPTH(2)) dut_a (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .in_halt   (in_halt),
    .flush     (flush),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_data  (a_out_data),
    .out_halt  (a_out_halt),
    .halted    (a_halted),
    .count     (a_count)
  );

  pipe_stage_buf #(.DATA_W(32), .DEPTH(3)) dut_b (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_data   (in_data),
    .in_halt   (in_halt),
    .flush     (flush),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_data  (b_out_data),
    .out_halt  (b_out_halt),
    .halted    (b_halted),
    .count     (b_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("a_count", 64'(a_count), 64'(q2.size()));
    checkOutput("a_out_valid", 64'(a_out_valid), 64'(q2.size() != 0));
    checkOutput("a_in_ready", 64'(a_in_ready), 64'(q2.size() < 2 && !hm2));
    checkOutput("a_halted", 64'(a_halted), 64'(hm2));
    if (q2.size() != 0) begin
      checkOutput("a_out_data", 64'(a_out_data), 64'(q2[0][31:0]));
      checkOutput("a_out_halt", 64'(a_out_halt), 64'(q2[0][32]));
    end
    checkOutput("b_count", 64'(b_count), 64'(q3.size()));
    checkOutput("b_out_valid", 64'(b_out_valid), 64'(q3.size() != 0));
    checkOutput("b_in_ready", 64'(b_in_ready), 64'(q3.size() < 3 && !hm3));
    checkOutput("b_halted", 64'(b_halted), 64'(hm3));
    if (q3.size() != 0) begin
      checkOutput("b_out_data", 64'(b_out_data), 64'(q3[0][31:0]));
      checkOutput("b_out_halt", 64'(b_out_halt), 64'(q3[0][32]));
    end
  endtask

  task automatic modelStep();
    logic [32:0] head;
    bit ps;
    bit pp;
    ps = in_valid && (q2.size() < 2) && !hm2;
    pp = (q2.size() != 0) && out_ready;
    if (RST) begin
      q2.delete();
      hm2 = 1'b0;
    end else if (flush) begin
      q2.delete();
    end else begin
      if (pp) begin
        head = q2.pop_front();
        if (head[32]) hm2 = 1'b1;
      end
      if (ps) q2.push_back({in_halt, in_data});
    end
    ps = in_valid && (q3.size() < 3) && !hm3;
    pp = (q3.size() != 0) && out_ready;
    if (RST) begin
      q3.delete();
      hm3 = 1'b0;
    end else if (flush) begin
      q3.delete();
    end else begin
      if (pp) begin
        head = q3.pop_front();
        if (head[32]) hm3 = 1'b1;
      end
      if (ps) q3.push_back({in_halt, in_data});
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic h,
                               input logic fl, input logic ordy, input logic rst);
    in_valid  = iv;
    in_data   = d;
    in_halt   = h;
    flush     = fl;
    out_ready = ordy;
    RST       = rst;
    #1;
    if (check_en) compareAll();
    @(posedge CLK);
    modelStep();
    @(negedge CLK);
    check_en = 1'b1;
  endtask

  initial begin
    @(negedge CLK);

    // Reset held for two cycles, then idle.
    applyStimulus(0, 32'h0, 0, 0, 0, 1);
    applyStimulus(0, 32'h0, 0, 0, 0, 1);
    checkOutput("rst_a_data", 64'(a_out_data), 64'h0);
    checkOutput("rst_b_data", 64'(b_out_data), 64'h0);
    checkOutput("rst_a_halt", 64'(a_out_halt), 64'h0);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);

    // Fill with back-pressure; third push must be refused by the 2-deep stage.
    applyStimulus(1, 32'hAAAA0001, 0, 0, 0, 0);
    applyStimulus(1, 32'hAAAA0002, 0, 0, 0, 0);
    checkOutput("fill_a_count", 64'(a_count), 64'd2);
    applyStimulus(1, 32'hAAAA0003, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 0, 0, 1, 0);
    checkOutput("drain_a_count", 64'(a_count), 64'd0);

    // Streaming through wraps with the consumer always ready.
    for (int i = 0; i < 10; i++) applyStimulus(1, 32'h10 + 32'(i), 0, 0, 1, 0);
    checkOutput("stream_b_count", 64'(b_count), 64'd1);
    applyStimulus(0, 32'h0, 0, 0, 1, 0);

    // Flush with simultaneous push and pop.
    applyStimulus(1, 32'h5, 0, 0, 0, 0);
    applyStimulus(1, 32'h6, 0, 0, 0, 0);
    applyStimulus(1, 32'h7, 0, 1, 1, 0);
    checkOutput("flush_a_valid", 64'(a_out_valid), 64'd0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 32'h0, 0, 0, 1, 0);

    // Halt: 0x21 carries the halt flag; 0x22 must still drain afterwards.
    applyStimulus(1, 32'h20, 0, 0, 0, 0);
    applyStimulus(1, 32'h21, 1, 0, 0, 0);
    applyStimulus(1, 32'h22, 0, 0, 1, 0);
    applyStimulus(1, 32'h22, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h23, 0, 0, 1, 0);
    applyStimulus(0, 32'h0, 0, 1, 0, 0);
    checkOutput("halt_sticky", 64'(a_halted), 64'd1);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);

    // Reset while holding entries, together with push and flush.
    applyStimulus(0, 32'h0, 0, 0, 0, 1);
    applyStimulus(1, 32'h31, 0, 0, 0, 0);
    applyStimulus(1, 32'h32, 0, 0, 0, 0);
    applyStimulus(1, 32'h33, 0, 1, 1, 1);
    checkOutput("midrst_count", 64'(a_count), 64'd0);
    checkOutput("midrst_ready", 64'(a_in_ready), 64'd1);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);

    // Randomised traffic against the reference models.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 32'($urandom), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 39) == 0));
    end
    applyStimulus(0, 32'h0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
